// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the iterative RV32M divider.
// Optional build macro: DIV_SPECIAL_FAST_EN (consumed in div_unit.sv).
package div_pkg;

   localparam int DIV_W = 32;

   // Operation encoding matches funct3[1:0] of the RV32M divide group.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
   localparam logic [DIV_W-1:0] INT_MIN       = 32'h80000000;

   // Magnitude of an operand; unsigned operations pass the value through.
   function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v,
                                                input logic             is_signed);
      return (is_signed && v[DIV_W-1]) ? (~v + 32'd1) : v;
   endfunction

   // Architecturally defined result for divide-by-zero and signed overflow.
   function automatic logic [DIV_W-1:0] special_result(input logic             div_zero,
                                                       input logic             is_rem,
                                                       input logic [DIV_W-1:0] dividend);
      if (div_zero)
         return is_rem ? dividend : DIV_BY_ZERO_Q;
      else
         return is_rem ? '0 : INT_MIN;
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The {remainder, dividend} pair shifts left one bit, the divisor is
// trial-subtracted, and the resulting quotient bit enters the dividend LSB.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] rem_i,
   input  logic [DIV_W-1:0] dvd_i,
   input  logic [DIV_W-1:0] dsr_i,
   output logic [DIV_W-1:0] rem_o,
   output logic [DIV_W-1:0] dvd_o
);

   logic [DIV_W:0]   shifted;
   logic [DIV_W+1:0] trial;
   logic             q_bit;

   // Trial subtraction with two guard bits so the borrow is unambiguous.
   always_comb begin
      shifted = {rem_i, dvd_i[DIV_W-1]};
      trial   = {1'b0, shifted} - {2'b00, dsr_i};
      q_bit   = ~trial[DIV_W+1];
      // The kept remainder is always below the divisor, so 32 bits suffice.
      rem_o   = q_bit ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
      dvd_o   = {dvd_i[DIV_W-2:0], q_bit};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) with valid/ready
// handshakes on both sides. Works on magnitudes and fixes signs at the end.
// Optional build macro: DIV_SPECIAL_FAST_EN - divide-by-zero and signed
// overflow jump straight from IDLE to DONE instead of iterating 32 cycles.
module div_unit
   import div_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DIV_W-1:0]  i_op_a,
   input  logic [DIV_W-1:0]  i_op_b,
   input  logic [1:0]        i_div_op,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DIV_W-1:0]  o_div_data
);

   div_state_e       state_q, state_d;
   logic [4:0]       cnt_q;
   logic [DIV_W-1:0] rem_q;
   logic [DIV_W-1:0] dvd_q;
   logic [DIV_W-1:0] dsr_q;
   logic [DIV_W-1:0] a_q;
   logic [DIV_W-1:0] result_q;
   logic             is_rem_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             zero_q;
   logic             ovf_q;

   logic             in_signed;
   logic             in_rem;
   logic             in_zero;
   logic             in_ovf;
   logic             in_special;

   logic [DIV_W-1:0] step_rem;
   logic [DIV_W-1:0] step_dvd;
   logic [DIV_W-1:0] quo_fix;
   logic [DIV_W-1:0] rem_fix;
   logic [DIV_W-1:0] calc_result;

   // Decode the incoming request: signedness, result select, special cases.
   always_comb begin
      in_signed  = (i_div_op == DIV) || (i_div_op == REM);
      in_rem     = (i_div_op == REM) || (i_div_op == REMU);
      in_zero    = (i_op_b == '0);
      in_ovf     = in_signed && (i_op_a == INT_MIN) && (i_op_b == DIV_BY_ZERO_Q);
      in_special = in_zero || in_ovf;
   end

   div_step u_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dsr_i (dsr_q),
      .rem_o (step_rem),
      .dvd_o (step_dvd)
   );

   // Final-step result: sign fix-up, then special-case override.
   always_comb begin
      quo_fix = neg_quo_q ? (~step_dvd + 32'd1) : step_dvd;
      rem_fix = neg_rem_q ? (~step_rem + 32'd1) : step_rem;
      if (zero_q || ovf_q)
         calc_result = special_result(zero_q, is_rem_q, a_q);
      else
         calc_result = is_rem_q ? rem_fix : quo_fix;
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
`ifdef DIV_SPECIAL_FAST_EN
               state_d = in_special ? DONE : CALC;
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            if (cnt_q == 5'd0) state_d = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture on accept, one iteration per CALC cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         a_q       <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  cnt_q     <= 5'd31;
                  rem_q     <= '0;
                  dvd_q     <= abs_val(i_op_a, in_signed);
                  dsr_q     <= abs_val(i_op_b, in_signed);
                  a_q       <= i_op_a;
                  is_rem_q  <= in_rem;
                  neg_quo_q <= in_signed && (i_op_a[DIV_W-1] ^ i_op_b[DIV_W-1]);
                  neg_rem_q <= in_signed && i_op_a[DIV_W-1];
                  zero_q    <= in_zero;
                  ovf_q     <= in_ovf;
`ifdef DIV_SPECIAL_FAST_EN
                  if (in_special)
                     result_q <= special_result(in_zero, in_rem, i_op_a);
`endif
               end
            end
            CALC: begin
               rem_q <= step_rem;
               dvd_q <= step_dvd;
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) result_q <= calc_result;
            end
            default: ;
         endcase
      end
   end

   assign o_div_data = result_q;

endmodule
